// File: rtl/cgu_rst_seq.sv
// Reset sequencer for the MMCM-derived clock domains: filters lock, staggers the
// domain reset releases, and serves software resets. Optional: CGU_RST_SEQ_TEST_BYPASS_EN.

module cgu_rst_seq_dom #(
   parameter int SWRST_W = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic req_i,
   input  logic clr_i,
   output logic busy_o
);
   localparam int CW = $clog2(SWRST_W) + 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // A request reloads the full width, so back-to-back requests stretch the pulse.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && req_i)
         cnt_d = CW'(SWRST_W);
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   assign busy_o = (cnt_d != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
endmodule

module cgu_rst_seq #(
   parameter int NUM_DOM   = 4,
   parameter int LOCK_FILT = 16,
   parameter int STAGGER   = 8,
   parameter int SWRST_W   = 8
) (
   input  logic               sys_clk_i,
   input  logic               por_rstn_i,
   input  logic               locked_i,
   input  logic [NUM_DOM-1:0] sw_rst_req_i,
   input  logic               lock_lost_clr_i,
   output logic [NUM_DOM-1:0] dom_rstn_o,
   output logic               seq_done_o,
   output logic               lock_lost_o,
   output logic [1:0]         state_o
`ifdef CGU_RST_SEQ_TEST_BYPASS_EN
   ,input logic               jtag_rst_sync_bypass_i
`endif
);
   localparam int FW = $clog2(LOCK_FILT) + 1;
   localparam int SW = $clog2(STAGGER) + 1;
   localparam int IW = $clog2(NUM_DOM) + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, FILT = 2'd1, REL = 2'd2, RUN = 2'd3} state_e;

   state_e             state_q, state_d;
   logic               lk_meta_q, lk_s_q;
   logic [FW-1:0]      filt_q, filt_d;
   logic [SW-1:0]      stg_q, stg_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [NUM_DOM-1:0] dom_rstn_q, dom_rstn_d;
   logic               seq_done_q, seq_done_d;
   logic               lock_lost_q, lock_lost_d;
   logic [NUM_DOM-1:0] busy;
   logic               sw_en, sw_clr, lost_set;

   assign sw_en    = (state_q == RUN) && lk_s_q;
   assign sw_clr   = (state_q == RUN) && !lk_s_q;
   assign lost_set = !lk_s_q && ((state_q == REL) || (state_q == RUN));

   for (genvar k = 0; k < NUM_DOM; k++) begin : g_dom
      cgu_rst_seq_dom #(.SWRST_W(SWRST_W)) u_dom (
         .clk_i  (sys_clk_i),
         .rst_ni (por_rstn_i),
         .en_i   (sw_en),
         .req_i  (sw_rst_req_i[k]),
         .clr_i  (sw_clr),
         .busy_o (busy[k])
      );
   end

   always_comb begin
      state_d    = state_q;
      filt_d     = filt_q;
      stg_d      = stg_q;
      idx_d      = idx_q;
      dom_rstn_d = dom_rstn_q;
      seq_done_d = seq_done_q;
      case (state_q)
         IDLE: begin
            dom_rstn_d = '0;
            if (lk_s_q) begin
               state_d = FILT;
               filt_d  = FW'(1);
            end
         end
         FILT: begin
            dom_rstn_d = '0;
            if (!lk_s_q) begin
               state_d = IDLE;
               filt_d  = '0;
            end else if (filt_q == FW'(LOCK_FILT)) begin
               state_d = REL;
               filt_d  = '0;
               stg_d   = '0;
               idx_d   = '0;
            end else begin
               filt_d = filt_q + 1'b1;
            end
         end
         REL: begin
            if (!lk_s_q) begin
               state_d    = IDLE;
               dom_rstn_d = '0;
            end else if (stg_q == SW'(STAGGER - 1)) begin
               for (int k = 0; k < NUM_DOM; k++)
                  if (idx_q == IW'(k)) dom_rstn_d[k] = 1'b1;
               stg_d = '0;
               idx_d = idx_q + 1'b1;
               if (idx_q == IW'(NUM_DOM - 1)) begin
                  state_d    = RUN;
                  seq_done_d = 1'b1;
               end
            end else begin
               stg_d = stg_q + 1'b1;
            end
         end
         default: begin
            if (!lk_s_q) begin
               state_d    = IDLE;
               dom_rstn_d = '0;
               seq_done_d = 1'b0;
            end else begin
               dom_rstn_d = ~busy;
            end
         end
      endcase
      // Set beats clear when both land in the same cycle.
      lock_lost_d = lost_set ? 1'b1 : (lock_lost_clr_i ? 1'b0 : lock_lost_q);
   end

   always_ff @(posedge sys_clk_i or negedge por_rstn_i) begin
      if (!por_rstn_i) begin
         lk_meta_q   <= 1'b0;
         lk_s_q      <= 1'b0;
         state_q     <= IDLE;
         filt_q      <= '0;
         stg_q       <= '0;
         idx_q       <= '0;
         dom_rstn_q  <= '0;
         seq_done_q  <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         lk_meta_q   <= locked_i;
         lk_s_q      <= lk_meta_q;
         state_q     <= state_d;
         filt_q      <= filt_d;
         stg_q       <= stg_d;
         idx_q       <= idx_d;
         dom_rstn_q  <= dom_rstn_d;
         seq_done_q  <= seq_done_d;
         lock_lost_q <= lock_lost_d;
      end
   end

`ifdef CGU_RST_SEQ_TEST_BYPASS_EN
   // Test-mode only: lets the scan/JTAG reset reach the domains without the sequencer.
   assign dom_rstn_o = jtag_rst_sync_bypass_i ? {NUM_DOM{por_rstn_i}} : dom_rstn_q;
`else
   assign dom_rstn_o = dom_rstn_q;
`endif
   assign seq_done_o  = seq_done_q;
   assign lock_lost_o = lock_lost_q;
   assign state_o     = state_q;
endmodule

// File: tb/tb_cgu_rst_seq.sv
// Bench for cgu_rst_seq: lock-run-length model checked every cycle, plus literal timing pins.
module tb_cgu_rst_seq;
   localparam int NUM_DOM   = 4;
   localparam int LOCK_FILT = 16;
   localparam int STAGGER   = 8;
   localparam int SWRST_W   = 8;
   localparam int REL_R     = LOCK_FILT + 1;
   localparam int RUN_R     = REL_R + NUM_DOM * STAGGER;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               locked = 1'b0;
   logic               clr = 1'b0;
   logic [NUM_DOM-1:0] req = '0;
   logic               byp = 1'b0;
   logic [NUM_DOM-1:0] dom;
   logic               done, lost;
   logic [1:0]         st;

   cgu_rst_seq #(.NUM_DOM(NUM_DOM), .LOCK_FILT(LOCK_FILT), .STAGGER(STAGGER), .SWRST_W(SWRST_W)) dut (
      .sys_clk_i       (clk),
      .por_rstn_i      (rst_n),
      .locked_i        (locked),
      .sw_rst_req_i    (req),
      .lock_lost_clr_i (clr),
      .dom_rstn_o      (dom),
      .seq_done_o      (done),
      .lock_lost_o     (lost),
      .state_o         (st)
`ifdef CGU_RST_SEQ_TEST_BYPASS_EN
      ,.jtag_rst_sync_bypass_i (byp)
`endif
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   // Model: r = consecutive cycles the sequencer has seen synchronised lock.
   int cyc = 0;
   int r = 0;
   int until_c [NUM_DOM];
   logic s1 = 1'b0, s2 = 1'b0, m_lost = 1'b0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            cyc = 0; r = 0; s1 = 0; s2 = 0; m_lost = 0;
            for (int k = 0; k < NUM_DOM; k++) until_c[k] = 0;
         end else begin
            logic lks;
            logic set;
            int   rp;
            cyc++;
            lks = s2; s2 = s1; s1 = locked;
            rp  = r;
            set = 1'b0;
            if (lks) begin
               r = (r < RUN_R) ? r + 1 : RUN_R;
               if (rp >= RUN_R)
                  for (int k = 0; k < NUM_DOM; k++)
                     if (req[k]) until_c[k] = cyc + SWRST_W;
            end else begin
               set = (rp > LOCK_FILT);
               r = 0;
               for (int k = 0; k < NUM_DOM; k++) until_c[k] = 0;
            end
            if (set) m_lost = 1'b1;
            else if (clr) m_lost = 1'b0;
         end
      end
   end

   function automatic logic [1:0] m_state();
      if (r == 0) return 2'd0;
      if (r <= LOCK_FILT) return 2'd1;
      if (r < RUN_R) return 2'd2;
      return 2'd3;
   endfunction

   function automatic logic [NUM_DOM-1:0] m_dom();
      logic [NUM_DOM-1:0] d;
      d = '0;
      if (byp) return {NUM_DOM{rst_n}};
      for (int k = 0; k < NUM_DOM; k++)
         if (r >= RUN_R) d[k] = (cyc >= until_c[k]);
         else            d[k] = (r >= REL_R + (k + 1) * STAGGER);
      return d;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      chk("dom_model",  32'(dom),  32'(m_dom()));
      chk("state_model", 32'(st),  32'(m_state()));
      chk("done_model", 32'(done), 32'(m_state() == 2'd3));
      chk("lost_model", 32'(lost), 32'(m_lost));
   end

   task automatic goto(input int n);
      while (cyc < n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dom", 32'(dom), 32'h0);
      chk("rst_state", 32'(st), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_lost", 32'(lost), 32'h0);
      rst_n = 1'b1;

      // Power-up sequence
      goto(9);   locked = 1'b1;
      goto(11);  chk("pu_idle11", 32'(st), 32'd0);
      goto(12);  chk("pu_filt12", 32'(st), 32'd1);
      goto(27);  chk("pu_filt27", 32'(st), 32'd1);
      goto(28);  chk("pu_rel28", 32'(st), 32'd2);
      goto(35);  chk("pu_dom35", 32'(dom), 32'h0);
      goto(36);  chk("pu_dom36", 32'(dom), 32'h1);
      goto(44);  chk("pu_dom44", 32'(dom), 32'h3);
      goto(52);  chk("pu_dom52", 32'(dom), 32'h7);
      goto(59);  chk("pu_done59", 32'(done), 32'h0);
      goto(60);  chk("pu_dom60", 32'(dom), 32'hF);
                 chk("pu_done60", 32'(done), 32'h1);

      // Software reset with extension on bit 0
      goto(69);  req = 4'b0101;
      goto(70);  req = '0; chk("sw_dom70", 32'(dom), 32'hA);
      goto(74);  req = 4'b0001;
      goto(75);  req = '0;
      goto(77);  chk("sw_dom77", 32'(dom), 32'hA);
      goto(78);  chk("sw_dom78", 32'(dom), 32'hE);
      goto(82);  chk("sw_dom82", 32'(dom), 32'hE);
      goto(83);  chk("sw_dom83", 32'(dom), 32'hF);

      // Lock loss in RUN, then clear
      goto(89);  locked = 1'b0;
      goto(91);  chk("ll_dom91", 32'(dom), 32'hF);
      goto(92);  chk("ll_dom92", 32'(dom), 32'h0);
                 chk("ll_lost92", 32'(lost), 32'h1);
                 chk("ll_state92", 32'(st), 32'd0);
      goto(94);  clr = 1'b1;
      goto(95);  clr = 1'b0; chk("ll_clr95", 32'(lost), 32'h0);

      // Relock with a 3-cycle glitch after 10 filter cycles
      goto(99);  locked = 1'b1;
      goto(109); locked = 1'b0;
      goto(111); chk("gl_filt111", 32'(st), 32'd1);
      goto(112); locked = 1'b1; chk("gl_idle112", 32'(st), 32'd0);
      goto(113); chk("gl_lost113", 32'(lost), 32'h0);
      goto(130); chk("gl_filt130", 32'(st), 32'd1);
      goto(131); chk("gl_rel131", 32'(st), 32'd2);

      // Request during REL is ignored
      goto(134); req = 4'b0001;
      goto(135); req = '0;
      goto(138); chk("ig_dom138", 32'(dom), 32'h0);
      goto(139); chk("ig_dom139", 32'(dom), 32'h1);
      goto(163); chk("ig_dom163", 32'(dom), 32'hF);

      // Lock loss and software request on the same cycle
      goto(177); locked = 1'b0;
      goto(179); req = 4'b1111; chk("lw_lost179", 32'(lost), 32'h0);
      goto(180); req = '0; chk("lw_dom180", 32'(dom), 32'h0);
                 chk("lw_lost180", 32'(lost), 32'h1);
      goto(185); chk("lw_dom185", 32'(dom), 32'h0);
`ifdef CGU_RST_SEQ_TEST_BYPASS_EN
      byp = 1'b1; #1 chk("byp_on", 32'(dom), 32'hF);
      goto(187); byp = 1'b0; #1 chk("byp_off", 32'(dom), 32'h0);
`endif

      // Reset in the middle of REL
      goto(189); locked = 1'b1;
      goto(212); chk("mr_rel212", 32'(st), 32'd2);
      #2 rst_n = 1'b0;
      #1 chk("mr_dom", 32'(dom), 32'h0);
      chk("mr_state", 32'(st), 32'd0);
      chk("mr_lost", 32'(lost), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      goto(5);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
